uart_cmd_master: RTL and testbench

- Initiator end of the board UART command protocol; the CPLD-side protocol block is the responder.
- Accepts one command request, builds a checksummed command frame and hands it to an n-byte UART sender (flag/complete handshake).
- Waits for the n-byte UART receiver to deliver the response frame, validates it, and retries on timeout or bad frame.
- Used in test fixtures and a host-emulation CPLD talking to the DUT board.

---
 rtl/uart_cmd_master.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// UART command initiator: frames a request, waits for the reply, and retries on timeout or a bad frame.
// Optional UART_CMD_MASTER_STATS_EN adds saturating completion and retry counters.
module uart_cmd_master #(
    parameter int CMD_N       = 4,
    parameter int RSP_N       = 6,
    parameter int TIMEOUT_CYC = 500000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_cmd,
    input  logic [(CMD_N-3)*8-1:0] req_payload,
    output logic                   tx_send_flag,
    output logic [CMD_N*8-1:0]     tx_data,
    input  logic                   tx_send_complete,
    input  logic                   rx_recv_flag,
    input  logic [RSP_N*8-1:0]     rx_data,
    output logic                   rsp_valid,
    output logic [(RSP_N-3)*8-1:0] rsp_data,
    output logic [1:0]             rsp_status,
    output logic                   busy
`ifdef UART_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]            stat_ok,
    output logic [15:0]            stat_err,
    output logic [15:0]            stat_retry
`endif
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_TMO  = 2'b01;
    localparam logic [1:0] ST_BAD  = 2'b10;
    localparam logic [1:0] ST_ECHO = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_TX, WAIT_RX, CHECK, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmo_q;
    logic [RW-1:0]        retry_q;
    logic [7:0]           cmd_q;
    logic [CMD_N*8-1:0]   tx_q;
    logic [RSP_N*8-1:0]   rx_q;
    logic [CMD_N*8-1:0]   frame_d;
    logic [7:0]           tx_sum;
    logic [7:0]           rx_sum;
    logic [1:0]           chk_status;
    logic                 tmo_hit;
    logic                 load_req;
    logic                 load_rx;
    logic                 fail;
    logic [1:0]           fail_st;
    logic                 retry_inc;
    logic                 fin;
    logic [1:0]           fin_st;

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign tx_send_flag = (state_q == SEND);
    assign rsp_valid    = (state_q == DONE);
    assign tx_data      = tx_q;
    assign tmo_hit      = (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        frame_d = {8'hA5, req_cmd, req_payload, 8'h00};
        tx_sum  = 8'h00;
        for (int i = 0; i < CMD_N - 1; i++)
            tx_sum = tx_sum + frame_d[(CMD_N-1-i)*8 +: 8];
        frame_d[7:0] = tx_sum;
    end

    // Header/checksum failures take priority over a wrong echo.
    always_comb begin
        rx_sum = 8'h00;
        for (int i = 0; i < RSP_N - 1; i++)
            rx_sum = rx_sum + rx_q[(RSP_N-1-i)*8 +: 8];
        if (rx_q[RSP_N*8-1 -: 8] != 8'h5A || rx_sum != rx_q[7:0])
            chk_status = ST_BAD;
        else if (rx_q[RSP_N*8-9 -: 8] != cmd_q)
            chk_status = ST_ECHO;
        else
            chk_status = ST_OK;
    end

    always_comb begin
        state_d   = state_q;
        load_req  = 1'b0;
        load_rx   = 1'b0;
        fail      = 1'b0;
        fail_st   = ST_OK;
        retry_inc = 1'b0;
        fin       = 1'b0;
        fin_st    = ST_OK;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_send_complete) state_d = WAIT_RX;
            WAIT_RX: begin
                if (rx_recv_flag) begin
                    load_rx = 1'b1;
                    state_d = CHECK;
                end else if (tmo_hit) begin
                    fail    = 1'b1;
                    fail_st = ST_TMO;
                end
            end
            CHECK: begin
                if (chk_status == ST_BAD) begin
                    fail    = 1'b1;
                    fail_st = ST_BAD;
                end else begin
                    fin    = 1'b1;
                    fin_st = chk_status;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fail) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_inc = 1'b1;
                state_d   = SEND;
            end else begin
                fin    = 1'b1;
                fin_st = fail_st;
            end
        end
        if (fin)
            state_d = DONE;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            retry_q    <= '0;
            cmd_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT_RX)
                tmo_q <= tmo_q + TW'(1);
            else
                tmo_q <= '0;
            if (load_req) begin
                retry_q <= '0;
                cmd_q   <= req_cmd;
                tx_q    <= frame_d;
            end else if (retry_inc) begin
                retry_q <= retry_q + RW'(1);
            end
            if (load_rx)
                rx_q <= rx_data;
            if (fin) begin
                rsp_status <= fin_st;
                rsp_data   <= rx_q[(RSP_N-2)*8-1:8];
            end
        end
    end

`ifdef UART_CMD_MASTER_STATS_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok    <= '0;
            stat_err   <= '0;
            stat_retry <= '0;
        end else begin
            if (fin && fin_st == ST_OK && stat_ok != 16'hFFFF)
                stat_ok <= stat_ok + 16'd1;
            if (fin && fin_st != ST_OK && stat_err != 16'hFFFF)
                stat_err <= stat_err + 16'd1;
            if (retry_inc && stat_retry != 16'hFFFF)
                stat_retry <= stat_retry + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed self-checking bench for uart_cmd_master (CMD_N=4, RSP_N=6, TIMEOUT_CYC=100).
// Build with UART_CMD_MASTER_STATS_EN to also check the statistics counters.
module tb_uart_cmd_master;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [7:0]  req_payload = 8'h00;
    logic        tx_send_flag;
    logic [31:0] tx_data;
    logic        tx_send_complete = 1'b0;
    logic        rx_recv_flag = 1'b0;
    logic [47:0] rx_data = 48'h0;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
`ifdef UART_CMD_MASTER_STATS_EN
    logic [15:0] stat_ok;
    logic [15:0] stat_err;
    logic [15:0] stat_retry;
`endif

    int vecs = 0;
    int errs = 0;

    localparam logic [47:0] GOOD10 = 48'h5A10_1122_33D0;
    localparam logic [47:0] BADCK  = 48'h5A10_1122_33D1;
    localparam logic [47:0] ECHO11 = 48'h5A11_1122_33D1;
    localparam logic [47:0] GOOD20 = 48'h5A20_AABB_CCAB;

    uart_cmd_master #(
        .CMD_N(4), .RSP_N(6), .TIMEOUT_CYC(100), .MAX_RETRY(2)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_payload(req_payload),
        .tx_send_flag(tx_send_flag),
        .tx_data(tx_data),
        .tx_send_complete(tx_send_complete),
        .rx_recv_flag(rx_recv_flag),
        .rx_data(rx_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .busy(busy)
`ifdef UART_CMD_MASTER_STATS_EN
        ,
        .stat_ok(stat_ok),
        .stat_err(stat_err),
        .stat_retry(stat_retry)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Issues a request in cycle N; returns sampled in cycle N+1.
    task automatic start_req(input logic [7:0] cmd, input logic [7:0] pl);
        int w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        vecs++;
        if (!req_ready) begin
            errs++;
            $display("FAIL start_req_ready: got %0b want 1", req_ready);
        end
        req_cmd     = cmd;
        req_payload = pl;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    // Reactive sender/receiver model answering every send with one frame.
    task automatic run_seq(input logic [47:0] frame, output int sends,
                           output int valids, output logic [1:0] st,
                           output logic [23:0] dat);
        int ph = 0;
        sends  = 0;
        valids = 0;
        st     = 2'b00;
        dat    = 24'h0;
        for (int c = 0; c < 60; c++) begin
            tx_send_complete = 1'b0;
            rx_recv_flag     = 1'b0;
            if (tx_send_flag) begin
                sends++;
                ph = 1;
            end else if (ph == 1) begin
                tx_send_complete = 1'b1;
                ph = 2;
            end else if (ph == 2) begin
                rx_data      = frame;
                rx_recv_flag = 1'b1;
                ph = 0;
            end
            if (rsp_valid) begin
                valids++;
                st  = rsp_status;
                dat = rsp_data;
            end
            tick();
        end
        tx_send_complete = 1'b0;
        rx_recv_flag     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vecs += 7;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
        if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (tx_send_flag !== 1'b0) begin errs++; $display("FAIL rst_send_flag: got %0b want 0", tx_send_flag); end
        if (tx_data !== 32'h0) begin errs++; $display("FAIL rst_tx_data: got %h want 0", tx_data); end
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
        if (rsp_status !== 2'b00) begin errs++; $display("FAIL rst_status: got %b want 00", rsp_status); end
        if (rsp_data !== 24'h0) begin errs++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        start_req(8'h10, 8'h33);
        vecs += 4;
        if (tx_send_flag !== 1'b1) begin errs++; $display("FAIL nom_flag_n1: got %0b want 1", tx_send_flag); end
        if (tx_data !== 32'hA510_33E8) begin errs++; $display("FAIL nom_tx_data: got %h want a51033e8", tx_data); end
        if (busy !== 1'b1) begin errs++; $display("FAIL nom_busy: got %0b want 1", busy); end
        if (req_ready !== 1'b0) begin errs++; $display("FAIL nom_ready: got %0b want 0", req_ready); end
        tick();
        vecs++;
        if (tx_send_flag !== 1'b0) begin errs++; $display("FAIL nom_flag_n2: got %0b want 0", tx_send_flag); end
        req_cmd   = 8'h55;
        req_valid = 1'b1;
        tx_send_complete = 1'b1;
        tick();
        tx_send_complete = 1'b0;
        tick();
        rx_data      = GOOD10;
        rx_recv_flag = 1'b1;
        req_valid    = 1'b0;
        tick();
        rx_recv_flag = 1'b0;
        vecs += 2;
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL nom_valid_m1: got %0b want 0", rsp_valid); end
        if (tx_data !== 32'hA510_33E8) begin errs++; $display("FAIL nom_tx_hold: got %h want a51033e8", tx_data); end
        tick();
        vecs += 3;
        if (rsp_valid !== 1'b1) begin errs++; $display("FAIL nom_valid_m2: got %0b want 1", rsp_valid); end
        if (rsp_status !== 2'b00) begin errs++; $display("FAIL nom_status: got %b want 00", rsp_status); end
        if (rsp_data !== 24'h112233) begin errs++; $display("FAIL nom_rsp_data: got %h want 112233", rsp_data); end
        tick();
        vecs += 4;
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL nom_valid_m3: got %0b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin errs++; $display("FAIL nom_ready_end: got %0b want 1", req_ready); end
        if (rsp_data !== 24'h112233) begin errs++; $display("FAIL nom_data_hold: got %h want 112233", rsp_data); end
        if (tx_send_flag !== 1'b0) begin errs++; $display("FAIL nom_no_resend: got %0b want 0", tx_send_flag); end
        tick();
    endtask

    task automatic test_timeout_retry();
        int k;
        start_req(8'h20, 8'h01);
        vecs++;
        if (tx_data !== 32'hA520_01C6) begin errs++; $display("FAIL tmo_tx_data: got %h want a52001c6", tx_data); end
        tick();
        tx_send_complete = 1'b1;
        tick();
        tx_send_complete = 1'b0;
        k = 1;
        while (!tx_send_flag && k < 200) begin
            tick();
            k++;
        end
        vecs += 2;
        if (k != 101) begin errs++; $display("FAIL tmo_resend_cycle: got %0d want 101", k); end
        if (tx_data !== 32'hA520_01C6) begin errs++; $display("FAIL tmo_tx_same: got %h want a52001c6", tx_data); end
        tick();
        tx_send_complete = 1'b1;
        tick();
        tx_send_complete = 1'b0;
        rx_data      = GOOD20;
        rx_recv_flag = 1'b1;
        tick();
        rx_recv_flag = 1'b0;
        tick();
        vecs += 3;
        if (rsp_valid !== 1'b1) begin errs++; $display("FAIL tmo_valid: got %0b want 1", rsp_valid); end
        if (rsp_status !== 2'b00) begin errs++; $display("FAIL tmo_status: got %b want 00", rsp_status); end
        if (rsp_data !== 24'hAABBCC) begin errs++; $display("FAIL tmo_rsp_data: got %h want aabbcc", rsp_data); end
        tick();
    endtask

    task automatic test_bad_checksum();
        int s, v;
        logic [1:0] st;
        logic [23:0] d;
        start_req(8'h10, 8'h33);
        run_seq(BADCK, s, v, st, d);
        vecs += 3;
        if (s != 3) begin errs++; $display("FAIL bad_sends: got %0d want 3", s); end
        if (v != 1) begin errs++; $display("FAIL bad_valids: got %0d want 1", v); end
        if (st !== 2'b10) begin errs++; $display("FAIL bad_status: got %b want 10", st); end
    endtask

    task automatic test_echo_mismatch();
        int s, v;
        logic [1:0] st;
        logic [23:0] d;
        start_req(8'h10, 8'h33);
        run_seq(ECHO11, s, v, st, d);
        vecs += 3;
        if (s != 1) begin errs++; $display("FAIL echo_sends: got %0d want 1", s); end
        if (v != 1) begin errs++; $display("FAIL echo_valids: got %0d want 1", v); end
        if (st !== 2'b11) begin errs++; $display("FAIL echo_status: got %b want 11", st); end
    endtask

    task automatic test_race_and_stray();
        int extra = 0;
        start_req(8'h10, 8'h33);
        tick();
        tx_send_complete = 1'b1;
        tick();
        tx_send_complete = 1'b0;
        for (int i = 0; i < 99; i++) begin
            if (tx_send_flag) extra++;
            tick();
        end
        rx_data      = GOOD10;
        rx_recv_flag = 1'b1;
        tick();
        rx_recv_flag = 1'b0;
        tick();
        vecs += 4;
        if (rsp_valid !== 1'b1) begin errs++; $display("FAIL race_valid: got %0b want 1", rsp_valid); end
        if (rsp_status !== 2'b00) begin errs++; $display("FAIL race_status: got %b want 00", rsp_status); end
        if (tx_send_flag !== 1'b0) begin errs++; $display("FAIL race_flag: got %0b want 0", tx_send_flag); end
        if (extra != 0) begin errs++; $display("FAIL race_extra_send: got %0d want 0", extra); end
        tick();
        for (int i = 0; i < 3; i++) begin
            rx_data          = GOOD10;
            rx_recv_flag     = 1'b1;
            tx_send_complete = 1'b1;
            tick();
            vecs += 2;
            if (rsp_valid !== 1'b0) begin errs++; $display("FAIL stray_valid: got %0b want 0", rsp_valid); end
            if (busy !== 1'b0) begin errs++; $display("FAIL stray_busy: got %0b want 0", busy); end
        end
        rx_recv_flag     = 1'b0;
        tx_send_complete = 1'b0;
        tick();
`ifdef UART_CMD_MASTER_STATS_EN
        vecs += 3;
        if (stat_ok !== 16'd3) begin errs++; $display("FAIL stat_ok: got %0d want 3", stat_ok); end
        if (stat_err !== 16'd2) begin errs++; $display("FAIL stat_err: got %0d want 2", stat_err); end
        if (stat_retry !== 16'd3) begin errs++; $display("FAIL stat_retry: got %0d want 3", stat_retry); end
`endif
    endtask

    task automatic test_reset_mid();
        int s, v;
        logic [1:0] st;
        logic [23:0] d;
        start_req(8'h10, 8'h33);
        tick();
        tx_send_complete = 1'b1;
        tick();
        tx_send_complete = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        vecs += 5;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %0b want 1", req_ready); end
        if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %0b want 0", busy); end
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %0b want 0", rsp_valid); end
        if (tx_data !== 32'h0) begin errs++; $display("FAIL mid_tx_data: got %h want 0", tx_data); end
        if (rsp_status !== 2'b00) begin errs++; $display("FAIL mid_status: got %b want 00", rsp_status); end
        tick();
        vecs++;
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_valid_hold: got %0b want 0", rsp_valid); end
        #2 rst_n = 1'b1;
        tick();
        start_req(8'h10, 8'h33);
        run_seq(GOOD10, s, v, st, d);
        vecs += 4;
        if (s != 1) begin errs++; $display("FAIL post_sends: got %0d want 1", s); end
        if (v != 1) begin errs++; $display("FAIL post_valids: got %0d want 1", v); end
        if (st !== 2'b00) begin errs++; $display("FAIL post_status: got %b want 00", st); end
        if (d !== 24'h112233) begin errs++; $display("FAIL post_data: got %h want 112233", d); end
`ifdef UART_CMD_MASTER_STATS_EN
        vecs += 2;
        if (stat_err !== 16'd0) begin errs++; $display("FAIL post_stat_err: got %0d want 0", stat_err); end
        if (stat_ok !== 16'd1) begin errs++; $display("FAIL post_stat_ok: got %0d want 1", stat_ok); end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout_retry();
        test_bad_checksum();
        test_echo_mismatch();
        test_race_and_stray();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
